sync_multi_port_ram: RTL and testbench

// Inferable synchronous RAM with one byte-enabled write port and NUM_RD_PORTS read ports.

---
 rtl/sync_ram_pkg.sv | 8 +
 rtl/sync_multi_port_ram_if.sv | 31 +++
 rtl/sync_ram_clear_fsm.sv | 83 ++++++++
 rtl/sync_multi_port_ram.sv | 136 +++++++++++++
 tb/tb_sync_multi_port_ram.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_ram_pkg.sv
// Shared types for the synchronous multi-port RAM: read-during-write policy
// and the clear controller state encoding.
package sync_ram_pkg;

  typedef enum logic {READ_FIRST, WRITE_FIRST} rdw_mode_e;
  typedef enum logic {IDLE, CLEAR} clr_state_e;

endpackage

// File: rtl/sync_multi_port_ram_if.sv
// Bus bundle for sync_multi_port_ram: clear control, one byte-enabled write
// port and NUM_RD_PORTS read ports. The RAM is the slave side.
interface sync_multi_port_ram_if #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2
);

  logic                                      Clear_SI;
  logic                                      Busy_SO;
  logic                                      WrEn_SI;
  logic [DATA_WIDTH/8-1:0]                   WrBe_SI;
  logic [ADDR_WIDTH-1:0]                     WrAddr_DI;
  logic [DATA_WIDTH-1:0]                     WrData_DI;
  logic                                      WrErr_SO;
  logic [NUM_RD_PORTS-1:0]                   RdEn_SI;
  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]   RdAddr_DI;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]   RdData_DO;
  logic [NUM_RD_PORTS-1:0]                   RdValid_SO;

  modport master (
    output Clear_SI, WrEn_SI, WrBe_SI, WrAddr_DI, WrData_DI, RdEn_SI, RdAddr_DI,
    input  Busy_SO, WrErr_SO, RdData_DO, RdValid_SO
  );

  modport slave (
    input  Clear_SI, WrEn_SI, WrBe_SI, WrAddr_DI, WrData_DI, RdEn_SI, RdAddr_DI,
    output Busy_SO, WrErr_SO, RdData_DO, RdValid_SO
  );

endinterface

// File: rtl/sync_ram_clear_fsm.sv
// Clear controller: walks every entry writing zeros while busy, otherwise
// forwards the user write port. Also flags dropped / out-of-range writes.
module sync_ram_clear_fsm
  import sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_DEPTH     = 1024,
  parameter int DATA_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RBI,
  input  logic                    Clear_SI,
  output logic                    Busy_SO,
  input  logic                    WrEn_SI,
  input  logic [DATA_WIDTH/8-1:0] WrBe_SI,
  input  logic [ADDR_WIDTH-1:0]   WrAddr_DI,
  input  logic [DATA_WIDTH-1:0]   WrData_DI,
  output logic                    WrErr_SO,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_err_q;
  logic                  wr_in_range;

  assign wr_in_range = ({1'b0, WrAddr_DI} < (ADDR_WIDTH + 1)'(DATA_DEPTH));

  // State, counter and write-error register
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= WrEn_SI && ((state_q == CLEAR) || !wr_in_range);
    end
  end

  // Next state and write-port mux; no array write happens while in reset
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_be    = WrBe_SI;
    mem_addr  = WrAddr_DI;
    mem_wdata = WrData_DI;
    case (state_q)
      IDLE: begin
        mem_we = Rst_RBI && WrEn_SI && wr_in_range;
        if (Clear_SI) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_we    = Rst_RBI;
        mem_be    = '1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign Busy_SO  = (state_q == CLEAR);
  assign WrErr_SO = wr_err_q;

endmodule

// File: rtl/sync_multi_port_ram.sv
// Inferable synchronous RAM, one byte-enabled write port, NUM_RD_PORTS read
// ports. Each read port owns a replica of the array so every replica maps to a
// simple dual-port memory template.
module sync_multi_port_ram
  import sync_ram_pkg::*;
#(
  parameter int        ADDR_WIDTH     = 10,
  parameter int        DATA_DEPTH     = 1024,
  parameter int        DATA_WIDTH     = 32,
  parameter int        NUM_RD_PORTS   = 2,
  parameter int        READ_LATENCY   = 1,
  parameter rdw_mode_e RDW_MODE       = READ_FIRST,
  parameter int        CLEAR_ON_RESET = 1
) (
  input logic                   Clk_CI,
  input logic                   Rst_RBI,
  sync_multi_port_ram_if.slave  bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  if (DATA_DEPTH > (2 ** ADDR_WIDTH)) begin : g_chk_depth
    $error("DATA_DEPTH exceeds the address space");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_chk_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 2)) begin : g_chk_lat
    $error("READ_LATENCY must be 1 or 2");
  end

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < (ADDR_WIDTH + 1)'(DATA_DEPTH));
  endfunction

  logic                  busy;
  logic                  mem_we;
  logic [NB-1:0]         mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  sync_ram_clear_fsm #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_DEPTH     (DATA_DEPTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .Clk_CI    (Clk_CI),
    .Rst_RBI   (Rst_RBI),
    .Clear_SI  (bus.Clear_SI),
    .Busy_SO   (busy),
    .WrEn_SI   (bus.WrEn_SI),
    .WrBe_SI   (bus.WrBe_SI),
    .WrAddr_DI (bus.WrAddr_DI),
    .WrData_DI (bus.WrData_DI),
    .WrErr_SO  (bus.WrErr_SO),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  assign bus.Busy_SO = busy;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_p0;
    logic                  vld_p0;

    assign rd_addr = bus.RdAddr_DI[p];
    assign rd_req  = bus.RdEn_SI[p] && !busy;

    // Stage p0: array write and registered read of this replica
    always_ff @(posedge Clk_CI) begin
      if (mem_we) begin
        for (int b = 0; b < NB; b++) begin
          if (mem_be[b]) mem[mem_addr[IDX_W-1:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      if (!Rst_RBI) begin
        rd_p0  <= '0;
        vld_p0 <= 1'b0;
      end else if (rd_req) begin
        vld_p0 <= 1'b1;
        if (!addr_ok(rd_addr)) begin
          rd_p0 <= '0;
        end else if ((RDW_MODE == WRITE_FIRST) && mem_we && (mem_addr == rd_addr)) begin
          rd_p0 <= merge_bytes(mem[rd_addr[IDX_W-1:0]], mem_wdata, mem_be);
        end else begin
          rd_p0 <= mem[rd_addr[IDX_W-1:0]];
        end
      end else begin
        vld_p0 <= 1'b0;
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd_p1;
      logic                  vld_p1;

      // Stage p1: optional output register, holds data between requests
      always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
          rd_p1  <= '0;
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) rd_p1 <= rd_p0;
        end
      end

      assign bus.RdData_DO[p]  = rd_p1;
      assign bus.RdValid_SO[p] = vld_p1;
    end else begin : g_lat1
      assign bus.RdData_DO[p]  = rd_p0;
      assign bus.RdValid_SO[p] = vld_p0;
    end
  end

endmodule

// File: tb/tb_sync_multi_port_ram.sv
// Scoreboard bench: two RAM instances (latency 1 / READ_FIRST and
// latency 2 / WRITE_FIRST) share the same directed stimulus.
module tb_sync_multi_port_ram;
  import sync_ram_pkg::*;

  localparam int AW  = 5;
  localparam int DD  = 16;
  localparam int DW  = 32;
  localparam int NRD = 3;
  localparam int NB  = DW / 8;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     clear;
  logic                     wr_en;
  logic [NB-1:0]            wr_be;
  logic [AW-1:0]            wr_addr;
  logic [DW-1:0]            wr_data;
  logic [NRD-1:0]           rd_en;
  logic [NRD-1:0][AW-1:0]   rd_addr;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  sync_multi_port_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRD)) ifa ();
  sync_multi_port_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRD)) ifb ();

  assign ifa.Clear_SI = clear;   assign ifb.Clear_SI = clear;
  assign ifa.WrEn_SI  = wr_en;   assign ifb.WrEn_SI  = wr_en;
  assign ifa.WrBe_SI  = wr_be;   assign ifb.WrBe_SI  = wr_be;
  assign ifa.WrAddr_DI = wr_addr; assign ifb.WrAddr_DI = wr_addr;
  assign ifa.WrData_DI = wr_data; assign ifb.WrData_DI = wr_data;
  assign ifa.RdEn_SI  = rd_en;   assign ifb.RdEn_SI  = rd_en;
  assign ifa.RdAddr_DI = rd_addr; assign ifb.RdAddr_DI = rd_addr;

  sync_multi_port_ram #(
    .ADDR_WIDTH(AW), .DATA_DEPTH(DD), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRD),
    .READ_LATENCY(1), .RDW_MODE(READ_FIRST), .CLEAR_ON_RESET(1)
  ) dut_a (
    .Clk_CI(clk), .Rst_RBI(rst_n), .bus(ifa)
  );

  sync_multi_port_ram #(
    .ADDR_WIDTH(AW), .DATA_DEPTH(DD), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRD),
    .READ_LATENCY(2), .RDW_MODE(WRITE_FIRST), .CLEAR_ON_RESET(1)
  ) dut_b (
    .Clk_CI(clk), .Rst_RBI(rst_n), .bus(ifb)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input bit which, input int p, input logic [31:0] d);
    exp_t e;
    int   sz;
    sz = which ? qb.size() : qa.size();
    if (sz == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_valid dut_%s port%0d: got %h expected no valid",
               which ? "b" : "a", p, d);
      return;
    end
    e = which ? qb.pop_front() : qa.pop_front();
    check($sformatf("rd_data_%s_p%0d", which ? "b" : "a", p), d, e.data);
    check($sformatf("rd_port_%s", which ? "b" : "a"), 32'(p), 32'(e.port));
    check($sformatf("rd_latency_%s_p%0d", which ? "b" : "a", p), 32'(cyc), 32'(e.cyc));
  endtask

  // Monitor: pops the scoreboard whenever a read port presents valid data
  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      if (ifa.RdValid_SO[p]) mon(1'b0, p, ifa.RdData_DO[p]);
      if (ifb.RdValid_SO[p]) mon(1'b1, p, ifb.RdData_DO[p]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    tick();
    clear = 1'b0;
    wr_en = 1'b0;
    wr_be = '0;
    rd_en = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_be   = be;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic [31:0] ea, input logic [31:0] eb);
    rd_en[p]   = 1'b1;
    rd_addr[p] = a;
    qa.push_back('{port: p, data: ea, cyc: cyc + 1});
    qb.push_back('{port: p, data: eb, cyc: cyc + 2});
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (ifa.Busy_SO && n < 40) begin
      n++;
      tick();
    end
    check(name, 32'(n), 32'(DD));
    check({name, "_b_idle"}, 32'(ifb.Busy_SO), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b0;
    wr_be   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    repeat (3) tick();

    // reset state
    check("rst_valid_a", 32'(ifa.RdValid_SO), 32'd0);
    check("rst_valid_b", 32'(ifb.RdValid_SO), 32'd0);
    check("rst_data_a", ifa.RdData_DO[0], 32'd0);
    check("rst_data_b", ifb.RdData_DO[2], 32'd0);
    check("rst_wrerr", 32'(ifa.WrErr_SO), 32'd0);
    check("rst_busy", 32'(ifa.Busy_SO), 32'd1);

    // 1: clear after reset, then every address reads zero
    rst_n = 1'b1;
    wait_clear("clr_init_len");
    for (int a = 0; a < DD; a++) begin
      for (int p = 0; p < NRD; p++) rd(p, AW'((a + p) % DD), 32'h0, 32'h0);
      cycle();
    end
    repeat (3) cycle();

    // 2: full write then byte-enabled partial write
    wr(5'd5, 4'hF, 32'hDEADBEEF);
    cycle();
    check("wrerr_legal", 32'(ifa.WrErr_SO), 32'd0);
    wr(5'd5, 4'b0010, 32'h0000AA00);
    cycle();
    rd(0, 5'd5, 32'hDEADAAEF, 32'hDEADAAEF);
    rd(1, 5'd5, 32'hDEADAAEF, 32'hDEADAAEF);
    cycle();
    rd(0, 5'd5, 32'hDEADAAEF, 32'hDEADAAEF);
    cycle();
    repeat (3) cycle();
    check("hold_a", ifa.RdData_DO[0], 32'hDEADAAEF);
    check("hold_b", ifb.RdData_DO[1], 32'hDEADAAEF);

    // 3: same-cycle read and write
    wr(5'd3, 4'hF, 32'h11111111);
    rd(0, 5'd3, 32'h00000000, 32'h11111111);
    cycle();
    wr(5'd3, 4'b0001, 32'h000000AB);
    rd(1, 5'd3, 32'h11111111, 32'h111111AB);
    cycle();
    rd(2, 5'd3, 32'h111111AB, 32'h111111AB);
    cycle();

    // 4: all ports on one address, out-of-range read and write, empty byte mask
    wr(5'd7, 4'hF, 32'h12345678);
    cycle();
    wr(5'd7, 4'h0, 32'hFFFFFFFF);
    cycle();
    check("wrerr_be0", 32'(ifa.WrErr_SO), 32'd0);
    for (int p = 0; p < NRD; p++) rd(p, 5'd7, 32'h12345678, 32'h12345678);
    cycle();
    for (int p = 0; p < NRD; p++) rd(p, 5'd20, 32'h0, 32'h0);
    cycle();
    wr(5'd20, 4'hF, 32'hFFFFFFFF);
    cycle();
    check("wrerr_oob_a", 32'(ifa.WrErr_SO), 32'd1);
    check("wrerr_oob_b", 32'(ifb.WrErr_SO), 32'd1);
    cycle();
    check("wrerr_pulse", 32'(ifa.WrErr_SO), 32'd0);
    rd(0, 5'd7, 32'h12345678, 32'h12345678);
    rd(1, 5'd20, 32'h0, 32'h0);
    rd(2, 5'd4, 32'h0, 32'h0);
    cycle();
    repeat (3) cycle();

    // 5: runtime clear, dropped write, reset mid-clear
    clear = 1'b1;
    cycle();
    check("clr_busy", 32'(ifa.Busy_SO), 32'd1);
    wr(5'd2, 4'hF, 32'hAAAAAAAA);
    rd_en[0]   = 1'b1;
    rd_addr[0] = 5'd5;
    cycle();
    check("wrerr_clr_a", 32'(ifa.WrErr_SO), 32'd1);
    check("wrerr_clr_b", 32'(ifb.WrErr_SO), 32'd1);
    check("clr_hold_a", ifa.RdData_DO[0], 32'h12345678);
    check("clr_hold_b", ifb.RdData_DO[0], 32'h12345678);
    repeat (8) cycle();
    check("clr_mid_busy", 32'(ifa.Busy_SO), 32'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    wait_clear("clr_restart_len");
    rd(0, 5'd5, 32'h0, 32'h0);
    rd(1, 5'd7, 32'h0, 32'h0);
    rd(2, 5'd2, 32'h0, 32'h0);
    cycle();
    repeat (4) cycle();

    check("sb_empty_a", 32'(qa.size()), 32'd0);
    check("sb_empty_b", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
